// File: rtl/waveform_loader_pkg.sv
// Shared types and constants for the host-side waveform ingest stage.
// Holds the FSM state encoding, error codes and header field positions.
package waveform_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_STREAM = 3'd2,
    ST_PAD    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_HDR = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_LEN_MSB   = 15;
  localparam int HDR_LEN_LSB   = 0;

endpackage

// File: rtl/waveform_loader.sv
// Validates a framed host packet and forwards exactly N words to the waveform
// streamer, padding short packets with zeros and draining long or bad ones.
module waveform_loader
  import waveform_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 4096,
  parameter logic [15:0] HDR_MAGIC = 16'hA5A5
) (
  input  logic         clk_in1,
  input  logic         areset,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [127:0] waveform_parameters,
  output logic         init_wf_write,
  input  logic         wf_write_ready,
  output logic [31:0]  wfin_axis_tdata,
  output logic         wfin_axis_tvalid,
  output logic         wfin_axis_tlast,
  output logic [3:0]   wfin_axis_tkeep,
  input  logic         wfin_axis_tready,
  output logic         load_done,
  output logic         load_err,
  output logic [1:0]   err_code
);

  localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic        hdr_last_q, hdr_last_d;
  logic        done_q, done_d;
  logic        errp_q, errp_d;
  logic        live_q;

  logic [15:0] hdr_magic;
  logic [15:0] hdr_len;
  logic        hdr_legal;
  logic        last_word;
  logic        s_hs;
  logic        w_hs;

  assign hdr_magic = s_axis_tdata[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  assign hdr_len   = s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_legal = (hdr_magic == HDR_MAGIC) && (hdr_len != 16'd0) && (hdr_len <= MaxLen);
  assign last_word = (cnt_q == (len_q - 16'd1));
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign w_hs      = wfin_axis_tvalid && wfin_axis_tready;

  // IDLE holds tready low until the first edge after reset so every output starts at 0.
  always_comb begin
    s_axis_tready    = 1'b0;
    init_wf_write    = 1'b0;
    wfin_axis_tvalid = 1'b0;
    wfin_axis_tdata  = 32'd0;
    wfin_axis_tlast  = 1'b0;
    unique case (state_q)
      ST_IDLE:   s_axis_tready = live_q;
      ST_REQ:    init_wf_write = 1'b1;
      ST_STREAM: begin
        wfin_axis_tvalid = s_axis_tvalid;
        wfin_axis_tdata  = s_axis_tdata;
        wfin_axis_tlast  = last_word;
        s_axis_tready    = wfin_axis_tready;
      end
      ST_PAD: begin
        wfin_axis_tvalid = 1'b1;
        wfin_axis_tlast  = last_word;
      end
      ST_DRAIN:  s_axis_tready = 1'b1;
      default:   s_axis_tready = 1'b0;
    endcase
  end

  assign wfin_axis_tkeep     = wfin_axis_tvalid ? 4'hF : 4'h0;
  assign waveform_parameters = {96'd0, 16'd0, len_q};
  assign load_done           = done_q;
  assign load_err            = errp_q;
  assign err_code            = err_q;

  // Short/long decisions look only at the word actually handshaken this cycle.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    hdr_last_d = hdr_last_q;
    done_d     = 1'b0;
    errp_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          len_d      = hdr_len;
          hdr_last_d = s_axis_tlast;
          if (hdr_legal) begin
            err_d   = ERR_NONE;
            state_d = ST_REQ;
          end else begin
            err_d = ERR_BAD_HDR;
            if (s_axis_tlast) begin
              errp_d = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_REQ: begin
        if (wf_write_ready) begin
          cnt_d = 16'd0;
          if (hdr_last_q) begin
            err_d   = ERR_SHORT;
            state_d = ST_PAD;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (w_hs) begin
          if (last_word) begin
            if (s_axis_tlast) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = ERR_LONG;
              state_d = ST_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (s_axis_tlast) begin
              err_d   = ERR_SHORT;
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (w_hs) begin
          if (last_word) begin
            done_d  = 1'b1;
            errp_d  = (err_q != ERR_NONE);
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs && s_axis_tlast) begin
          errp_d  = (err_q != ERR_NONE);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      err_q      <= ERR_NONE;
      hdr_last_q <= 1'b0;
      done_q     <= 1'b0;
      errp_q     <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      hdr_last_q <= hdr_last_d;
      done_q     <= done_d;
      errp_q     <= errp_d;
      live_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_waveform_loader.sv
// Directed bench for waveform_loader: a table of packet scenarios with
// hand-computed outcomes, plus reset and mid-packet reset sequences.
module tb_waveform_loader;

  logic         clk_in1 = 1'b0;
  logic         areset = 1'b1;
  logic [31:0]  s_axis_tdata = 32'd0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [127:0] waveform_parameters;
  logic         init_wf_write;
  logic         wf_write_ready = 1'b0;
  logic [31:0]  wfin_axis_tdata;
  logic         wfin_axis_tvalid;
  logic         wfin_axis_tlast;
  logic [3:0]   wfin_axis_tkeep;
  logic         wfin_axis_tready = 1'b1;
  logic         load_done;
  logic         load_err;
  logic [1:0]   err_code;

  typedef struct {
    logic [31:0] hdr;
    int          hostWords;
    int          readyDelay;
    bit          toggleReady;
    int          expWords;
    int          passWords;
    logic [1:0]  expErr;
    int          expDone;
    int          expErrPulses;
    int          expInit;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int errCount = 0;
  int initCycles = 0;
  int readyDelay = 0;
  bit toggleReady = 1'b0;
  logic [31:0] dataQ[$];
  bit          lastQ[$];
  logic [3:0]  keepQ[$];

  waveform_loader dut (
    .clk_in1             (clk_in1),
    .areset              (areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .waveform_parameters (waveform_parameters),
    .init_wf_write       (init_wf_write),
    .wf_write_ready      (wf_write_ready),
    .wfin_axis_tdata     (wfin_axis_tdata),
    .wfin_axis_tvalid    (wfin_axis_tvalid),
    .wfin_axis_tlast     (wfin_axis_tlast),
    .wfin_axis_tkeep     (wfin_axis_tkeep),
    .wfin_axis_tready    (wfin_axis_tready),
    .load_done           (load_done),
    .load_err            (load_err),
    .err_code            (err_code)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Streamer model: accepts a write request after readyDelay cycles of init_wf_write.
  always @(negedge clk_in1) begin
    if (!areset) begin
      if (load_done) doneCount++;
      if (load_err) errCount++;
      if (wfin_axis_tvalid && wfin_axis_tready) begin
        dataQ.push_back(wfin_axis_tdata);
        lastQ.push_back(wfin_axis_tlast);
        keepQ.push_back(wfin_axis_tkeep);
      end
      if (init_wf_write) begin
        initCycles++;
        wf_write_ready = (initCycles >= readyDelay + 1);
      end else begin
        wf_write_ready = 1'b0;
      end
      if (s_axis_tvalid && wfin_axis_tvalid)
        checkOutput("bp_ready_follow", 64'(s_axis_tready), 64'(wfin_axis_tready));
    end
  end

  always @(posedge clk_in1) begin
    #1;
    if (toggleReady) wfin_axis_tready = ~wfin_axis_tready;
    else wfin_axis_tready = 1'b1;
  end

  task automatic sendWord(input logic [31:0] d, input logic l, output bit ok);
    bit hs;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in1);
      hs = s_axis_tready;
      @(posedge clk_in1);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bit ok;
    int waited;
    logic [31:0] expD;
    doneCount   = 0;
    errCount    = 0;
    initCycles  = 0;
    dataQ.delete();
    lastQ.delete();
    keepQ.delete();
    readyDelay  = v.readyDelay;
    toggleReady = v.toggleReady;
    sendWord(v.hdr, v.hostWords == 0, ok);
    checkOutput($sformatf("v%0d_hdr_hs", idx), 64'(ok), 64'd1);
    for (int i = 0; i < v.hostWords; i++) begin
      sendWord(32'(i + 1), i == v.hostWords - 1, ok);
      checkOutput($sformatf("v%0d_word%0d_hs", idx, i), 64'(ok), 64'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    waited = 0;
    while (doneCount + errCount == 0 && waited < 300) begin
      @(posedge clk_in1);
      waited++;
    end
    repeat (3) @(posedge clk_in1);
    #1;
    toggleReady = 1'b0;
    checkOutput($sformatf("v%0d_pulse_seen", idx), 64'(doneCount + errCount > 0), 64'd1);
    checkOutput($sformatf("v%0d_err_code", idx), 64'(err_code), 64'(v.expErr));
    checkOutput($sformatf("v%0d_done_pulses", idx), 64'(doneCount), 64'(v.expDone));
    checkOutput($sformatf("v%0d_err_pulses", idx), 64'(errCount), 64'(v.expErrPulses));
    checkOutput($sformatf("v%0d_init_cycles", idx), 64'(initCycles), 64'(v.expInit));
    checkOutput($sformatf("v%0d_word_count", idx), 64'(dataQ.size()), 64'(v.expWords));
    for (int k = 0; k < dataQ.size() && k < v.expWords; k++) begin
      expD = (k < v.passWords) ? 32'(k + 1) : 32'd0;
      checkOutput($sformatf("v%0d_wfin%0d_data", idx, k), 64'(dataQ[k]), 64'(expD));
      checkOutput($sformatf("v%0d_wfin%0d_last", idx, k), 64'(lastQ[k]), 64'(k == v.expWords - 1));
      checkOutput($sformatf("v%0d_wfin%0d_keep", idx, k), 64'(keepQ[k]), 64'hF);
    end
    if (v.expInit > 0) begin
      checkOutput($sformatf("v%0d_params_n", idx), 64'(waveform_parameters[31:0]), 64'(v.hdr[15:0]));
      checkOutput($sformatf("v%0d_params_hi", idx), 64'(|waveform_parameters[127:32]), 64'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    checkOutput({tag, "_init"}, 64'(init_wf_write), 64'd0);
    checkOutput({tag, "_wfin_valid"}, 64'(wfin_axis_tvalid), 64'd0);
    checkOutput({tag, "_wfin_last"}, 64'(wfin_axis_tlast), 64'd0);
    checkOutput({tag, "_wfin_keep"}, 64'(wfin_axis_tkeep), 64'd0);
    checkOutput({tag, "_load_done"}, 64'(load_done), 64'd0);
    checkOutput({tag, "_load_err"}, 64'(load_err), 64'd0);
    checkOutput({tag, "_err_code"}, 64'(err_code), 64'd0);
    checkOutput({tag, "_params"}, 64'(|waveform_parameters), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    // hdr, host words, ready delay, toggle, exp words, passed words, err, done, err pulses, init cycles
    vecs[0] = '{32'hA5A50004, 4, 3, 1'b0, 4, 4, 2'd0, 1, 0, 4};
    vecs[1] = '{32'hA5A50004, 2, 0, 1'b0, 4, 2, 2'd2, 1, 1, 1};
    vecs[2] = '{32'hA5A50002, 4, 1, 1'b0, 2, 2, 2'd3, 0, 1, 2};
    vecs[3] = '{32'h12340004, 3, 0, 1'b0, 0, 0, 2'd1, 0, 1, 0};
    vecs[4] = '{32'hA5A50000, 3, 0, 1'b0, 0, 0, 2'd1, 0, 1, 0};
    vecs[5] = '{32'hA5A51001, 3, 0, 1'b0, 0, 0, 2'd1, 0, 1, 0};
    vecs[6] = '{32'hA5A50008, 8, 0, 1'b1, 8, 8, 2'd0, 1, 0, 1};
    vecs[7] = '{32'hA5A50003, 0, 0, 1'b0, 3, 0, 2'd2, 1, 1, 1};
    vecs[8] = '{32'h12340001, 0, 0, 1'b0, 0, 0, 2'd1, 0, 1, 0};
    vecs[9] = '{32'hA5A50001, 1, 2, 1'b0, 1, 1, 2'd0, 1, 0, 3};

    repeat (2) @(posedge clk_in1);
    #1;
    checkAllZero("reset");
    @(negedge clk_in1);
    areset = 1'b0;
    #1;
    checkAllZero("post_reset");
    @(posedge clk_in1);
    #1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Abort a packet after 3 of 8 words; nothing may complete or report.
    readyDelay  = 0;
    toggleReady = 1'b0;
    initCycles  = 0;
    sendWord(32'hA5A50008, 1'b0, ok);
    checkOutput("midrst_hdr_hs", 64'(ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      sendWord(32'(i + 1), 1'b0, ok);
      checkOutput($sformatf("midrst_word%0d_hs", i), 64'(ok), 64'd1);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd4;
    #2;
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    checkAllZero("midrst");
    doneCount = 0;
    errCount  = 0;
    repeat (2) @(posedge clk_in1);
    @(negedge clk_in1);
    areset = 1'b0;
    repeat (5) @(posedge clk_in1);
    #1;
    checkOutput("midrst_no_done", 64'(doneCount), 64'd0);
    checkOutput("midrst_no_err", 64'(errCount), 64'd0);
    applyStimulus(vecs[0], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/waveform_loader.md
# waveform_loader

Host-side ingest stage feeding the waveform BRAM streamer's write port.
- Takes a framed AXI-Stream packet from the host command path: one header word followed by N 32-bit waveform words.
- Validates the header and requests a write via `init_wf_write`/`wf_write_ready`, publishing N in `waveform_parameters[31:0]`.
- Forwards exactly N words on `wfin_axis_*` with a self-generated `tlast`, so the downstream write always sees a length-consistent stream regardless of host framing errors.

## Interface
Parameters:
- `MAX_WORDS`, default 4096: largest legal N. Must be ≤ 65535.
- `HDR_MAGIC`, default 16'hA5A5: required value of header bits [31:16].

Ports (one clock; reset is asynchronous and active-high):
- `clk_in1`  in  1  system clock
- `areset`  in  1  asynchronous, active-high reset
- `s_axis_tdata`  in  32  host packet word
- `s_axis_tvalid`  in  1  host word valid
- `s_axis_tlast`  in  1  host end of packet
- `s_axis_tready`  out  1  loader accepts host word
- `waveform_parameters`  out  128  [31:0] = N, [127:32] = 0
- `init_wf_write`  out  1  write request to streamer
- `wf_write_ready`  in  1  streamer idle and able to accept a request
- `wfin_axis_tdata`  out  32  waveform word to streamer
- `wfin_axis_tvalid`  out  1  waveform word valid
- `wfin_axis_tlast`  out  1  last of N words
- `wfin_axis_tkeep`  out  4  4'hF while valid, else 0
- `wfin_axis_tready`  in  1  streamer accepts word
- `load_done`  out  1  one-cycle pulse: N words delivered
- `load_err`  out  1  one-cycle pulse: packet error
- `err_code`  out  2  0 none, 1 bad header, 2 short packet, 3 long packet; held until next header accepted

## Operation
- Header word: [31:16] magic, [15:0] N.
- Header is legal iff magic == `HDR_MAGIC` and 1 ≤ N ≤ `MAX_WORDS`.
- States and transitions:
  - IDLE: `s_axis_tready`=1. On header handshake:
    - Legal: latch N, clear `err_code`, go to REQ.
    - Illegal: set `err_code`=1 and go to DRAIN. If the header carries `tlast`, pulse `load_err` and stay in IDLE instead.
  - REQ: `s_axis_tready`=0, `init_wf_write`=1. Request is accepted in the cycle where `wf_write_ready`=1. Then:
    - Go to PAD (`err_code`=2) if the header carried `tlast`.
    - Otherwise go to STREAM.
  - STREAM: combinational pass-through. `wfin_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`wfin_axis_tready`, data passes straight through. Word counter `cnt` (16 b, starts at 0) increments per handshake.
    - `wfin_axis_tlast` = (`cnt`==N-1).
    - Last word with host `tlast`: done, go to IDLE.
    - Last word without host `tlast`: `err_code`=3, go to DRAIN.
    - Host `tlast` on an earlier word: `err_code`=2, go to PAD.
  - PAD: `s_axis_tready`=0. Emit zero words, `tvalid`=1, until `cnt`==N-1 is handshaken (`tlast` on it), then go to IDLE.
  - DRAIN: `s_axis_tready`=1, `wfin` idle. Discard host words through host `tlast`, then go to IDLE.
- Reporting:
  - `load_done` pulses on completion of STREAM or PAD.
  - `load_err` pulses on exit from PAD or DRAIN with a nonzero code, and on the single-word bad header.
- `waveform_parameters` holds N from the header handshake until the next header.
- `init_wf_write` is never asserted outside REQ.

## Timing
- All outputs 0 during and immediately after reset. `areset` mid-packet aborts to IDLE asynchronously, with no completion or error pulse. The host must restart the packet.
- Header handshake to `init_wf_write` high: 1 cycle.
- `init_wf_write` stays high until the cycle in which `wf_write_ready` is sampled high. The FSM leaves REQ on the next edge.
- STREAM data path: zero latency; backpressure passes through in the same cycle.
- `load_done`/`load_err`: registered, 1 cycle after the final handshake.
- Simultaneous events: host `tlast` on word N-1 is a clean done. Short/long detection uses only the handshaken word.

## Structure
- Package `waveform_loader_pkg` holds:
  - the state enum (IDLE, REQ, STREAM, PAD, DRAIN);
  - the err code constants;
  - the header field positions.
- Flat module; no sub-module is natural. One 5-state FSM plus a 16-bit counter.

## Test plan
- **Nominal:** header 0xA5A50004, data 1..4 with `tlast` on 4; `wf_write_ready` low 3 cycles, then high. Required: `init_wf_write` high until ready is sampled high; `waveform_parameters[31:0]`=4; `wfin` carries 1,2,3,4 with `tlast` on 4; `load_done` pulses once; `err_code`=0.
- **Short:** header N=4, host sends 1,2 with `tlast` on 2. Required: `wfin` carries 1,2,0,0 with `tlast` on the 4th; `load_done` and `load_err` pulse; `err_code`=2.
- **Long:** header N=2, host sends 1..4. Required: `wfin` carries 1,2 with `tlast` on 2; words 3,4 are absorbed; `load_err` pulses after word 4; `err_code`=3.
- **Bad header:** header 0x12340004 followed by 3 words. Required: `init_wf_write` never asserted; all words drained; `err_code`=1. Repeat with N=0 and N=`MAX_WORDS`+1 for the same result.
- **Backpressure:** N=8, `wfin_axis_tready` toggling every cycle. Required: 8 words delivered in order with no loss or duplication; `s_axis_tready` equals `wfin_axis_tready` each cycle.
- **Reset mid-packet:** assert `areset` after 3 of 8 words. Required: outputs go to 0 immediately; a following legal packet loads normally.
